zero_count_normalizer: RTL and testbench
========================================

ZERO_COUNT_NORMALIZER -- requirements
Module: zero_count_normalizer

Interface
REQ-001 Parameter SizeMantissa, default 23, mantissa field width; W = SizeMantissa+2 is the datapath width.
REQ-002 Parameter ChunkBits, default 8, bits examined per cycle; legal range 1..W.
REQ-003 Derived CW = $clog2(W+1), the count width, so that the all-zero count W is representable.
REQ-004 clk  input  1  rising-edge clock, the only clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  block idle and able to accept.
REQ-008 in_mantissa  input  W  operand.
REQ-009 in_mode  input  1  0 = count trailing zeros, 1 = count leading zeros.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_count  output  CW  zero count.
REQ-013 out_mantissa  output  W  normalized operand.
REQ-014 out_zero  output  1  operand was all zeros.

Function
REQ-015 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-017 On in_valid&&in_ready, the block SHALL capture operand and mode into a working register, clear the count, and enter BUSY.
REQ-018 Each BUSY cycle SHALL examine min(ChunkBits, W-count) bits at the LSB end (mode 0) or the MSB end (mode 1) of the working register.
REQ-019 If the examined chunk is all zero, the block SHALL add the chunk width to the count, shift the working register by that width toward the examined end with zero fill, and remain in BUSY.
REQ-020 Otherwise it SHALL add the zeros preceding the first 1 in the chunk, shift by that amount, and enter DONE.
REQ-021 If the count reaches W, the block SHALL enter DONE with out_zero=1 and out_count=W.
REQ-022 The count SHALL never exceed W; the final chunk is partial when W is not a multiple of ChunkBits.
REQ-023 Latency: out_valid SHALL rise N clock edges after the accept edge, where N = floor(z/ChunkBits)+1 for z zeros, and N = ceil(W/ChunkBits) when the operand is all zero.
REQ-024 Result: mode 0 SHALL place the first 1 at bit 0 (right shift by z); mode 1 SHALL place it at bit W-1 (left shift by z); the all-zero result is 0.
REQ-025 In DONE, out_count, out_mantissa and out_zero SHALL be held stable while out_ready=0.
REQ-026 DONE with out_ready=1 SHALL return to IDLE on that edge; in_ready first rises the following cycle, with no same-cycle pass-through.
REQ-027 in_valid, in_mantissa and in_mode SHALL be ignored outside IDLE.
REQ-028 in_mode SHALL be sampled only at accept; later changes have no effect on the operation in progress.

Reset
REQ-029 rst_n=0 SHALL immediately, regardless of clk, force IDLE, in_ready=1, out_valid=0, out_count=0, out_mantissa=0, out_zero=0, and clear the working register.
REQ-030 Reset asserted in BUSY or DONE SHALL abort the operation with no result emitted.
REQ-031 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification (defaults: W=25, ChunkBits=8, CW=5)
REQ-032 Trailing, in_mantissa=25'h0000100, out_ready=1 -> out_valid 2 edges after accept, out_count=8, out_mantissa=25'h0000001, out_zero=0.
REQ-033 Leading, in_mantissa=25'h0010000 -> 2 edges, out_count=8, out_mantissa=25'h1000000.
REQ-034 Either mode, in_mantissa=0 -> 4 edges, out_count=25, out_zero=1, out_mantissa=0; also in_mantissa=25'h1000000 in trailing -> 4 edges, out_count=24, out_mantissa=1.
REQ-035 Back-pressure: out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0 throughout; in_valid pulses are ignored; in_ready=1 one cycle after out_ready rises.
REQ-036 rst_n pulsed low in the 1st BUSY cycle of an all-zero operand -> out_valid never rises, in_ready=1 during reset, and the next operand 25'h1 trailing returns out_count=0 after 1 edge.
REQ-037 10000 random operands in random modes with random out_ready -> count, shift, zero flag and latency match the reference model; 0 errors reported.

Source files
------------

// File: rtl/zero_count_normalizer.sv
`default_nettype none
// ============================================================================
// Module      : zero_count_normalizer
// Description : Iterative leading/trailing zero counter and normalizer.
//               An accepted operand is scanned ChunkBits bits per cycle from
//               the LSB end (trailing mode) or MSB end (leading mode). Every
//               all-zero chunk is counted and shifted out. The first chunk
//               that holds a 1 completes the count, and the operand is then
//               shifted so that this 1 sits at bit 0 (trailing) or bit W-1
//               (leading).
// Ports       : clk, rst_n             - clock, async active-low reset
//               in_valid/in_ready      - request handshake (ready only idle)
//               in_mantissa, in_mode   - operand; mode 0=trailing, 1=leading
//               out_valid/out_ready    - result handshake
//               out_count              - zero count (W when operand is zero)
//               out_mantissa           - normalized operand
//               out_zero               - operand was all zeros
// Revision    : 1.0 - initial release
// ============================================================================
module zero_count_normalizer #(
    parameter  int SizeMantissa = 23,
    parameter  int ChunkBits    = 8,
    localparam int W            = SizeMantissa + 2,
    localparam int CW           = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_mantissa,
    input  logic          in_mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_count,
    output logic [W-1:0]  out_mantissa,
    output logic          out_zero
);

    localparam logic [CW-1:0] c_chunk = CW'(ChunkBits);
    localparam logic [CW-1:0] c_full  = CW'(W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [W-1:0]         r_work;
    logic                 r_mode;
    logic [CW-1:0]        r_count;
    logic                 r_zero;

    logic [ChunkBits-1:0] w_bits;     // chunk bits, index 0 = examined end
    logic [CW-1:0]        w_remain;
    logic [CW-1:0]        w_width;
    logic                 w_found;
    logic [CW-1:0]        w_first;
    logic [CW-1:0]        w_shamt;
    logic [CW-1:0]        w_sum;
    logic [W-1:0]         w_shifted;

    // Orient the chunk so that bit 0 is always the bit nearest the examined
    // end; the priority search below is then identical for both modes.
    for (genvar g = 0; g < ChunkBits; g++) begin : g_bits
        assign w_bits[g] = r_mode ? r_work[W-1-g] : r_work[g];
    end

    always_comb begin
        w_remain = c_full - r_count;
        // The last chunk is partial when W is not a multiple of ChunkBits.
        w_width  = (w_remain < c_chunk) ? w_remain : c_chunk;
        w_found  = 1'b0;
        w_first  = '0;
        // Descending scan: the lowest set position inside the width wins.
        for (int i = ChunkBits - 1; i >= 0; i--) begin
            if (w_bits[i] && (CW'(i) < w_width)) begin
                w_found = 1'b1;
                w_first = CW'(i);
            end
        end
        w_shamt   = w_found ? w_first : w_width;
        w_sum     = r_count + w_shamt;
        w_shifted = r_mode ? (r_work << w_shamt) : (r_work >> w_shamt);
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next = BUSY;
                end
            end
            BUSY: begin
                if (w_found || (w_sum == c_full)) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath. Result registers double as the working state, so they are
    // naturally held while DONE waits for out_ready.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work  <= '0;
            r_mode  <= 1'b0;
            r_count <= '0;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_work  <= in_mantissa;
                        r_mode  <= in_mode;
                        r_count <= '0;
                        r_zero  <= 1'b0;
                    end
                end
                BUSY: begin
                    r_work  <= w_shifted;
                    r_count <= w_sum;
                    r_zero  <= !w_found && (w_sum == c_full);
                end
                default: begin
                end
            endcase
        end
    end

    assign out_count    = r_count;
    assign out_mantissa = r_work;
    assign out_zero     = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_zero_count_normalizer.sv
`default_nettype none
// ============================================================================
// Module      : tb_zero_count_normalizer
// Description : Self-checking bench for zero_count_normalizer. Directed
//               cases, back-pressure, mid-operation reset and random
//               operands, all compared against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_zero_count_normalizer;

    localparam int SM = 23;
    localparam int C  = 8;
    localparam int W  = SM + 2;
    localparam int CW = $clog2(W + 1);

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_mantissa;
    logic          in_mode;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_count;
    logic [W-1:0]  out_mantissa;
    logic          out_zero;

    int vectors     = 0;
    int miscompares = 0;

    zero_count_normalizer #(
        .SizeMantissa (SM),
        .ChunkBits    (C)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_mantissa  (in_mantissa),
        .in_mode      (in_mode),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_count    (out_count),
        .out_mantissa (out_mantissa),
        .out_zero     (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: count zeros from the chosen end, shift, derive latency.
    task automatic model(input logic [W-1:0] m, input logic md,
                         output int z, output logic [W-1:0] res, output int lat);
        z = 0;
        while (z < W && ((md ? m[W-1-z] : m[z]) == 1'b0)) z++;
        if (z == W) begin
            res = '0;
            lat = (W + C - 1) / C;
        end else begin
            res = md ? (m << z) : (m >> z);
            lat = z / C + 1;
        end
    endtask

    task automatic run_op(input logic [W-1:0] m, input logic md, input int hold);
        int z, lat, n;
        logic [W-1:0] res;
        model(m, md, z, res, lat);
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid    = 1'b1;
        in_mantissa = m;
        in_mode     = md;
        out_ready   = (hold == 0);
        @(posedge clk); #1;
        chk("in_ready_busy", 32'(in_ready), 32'd0);
        // Inputs are don't-care until the block is idle again.
        in_valid    = 1'($urandom);
        in_mantissa = W'($urandom);
        in_mode     = 1'($urandom);
        n = 0;
        while (!out_valid && n < W + 4) begin
            @(posedge clk); #1;
            n++;
            in_valid    = 1'($urandom);
            in_mantissa = W'($urandom);
            in_mode     = 1'($urandom);
        end
        in_valid = 1'b0;
        chk("latency", 32'(n), 32'(lat));
        chk("count", 32'(out_count), 32'(z));
        chk("mantissa", 32'(out_mantissa), 32'(res));
        chk("zero", 32'(out_zero), 32'(z == W));
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_count", 32'(out_count), 32'(z));
            chk("hold_mantissa", 32'(out_mantissa), 32'(res));
            chk("hold_zero", 32'(out_zero), 32'(z == W));
            in_valid = 1'($urandom);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("valid_clear", 32'(out_valid), 32'd0);
        chk("in_ready_back", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [W-1:0] r;
        int           k;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_mantissa = '0;
        in_mode     = 1'b0;
        out_ready   = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(out_count), 32'd0);
        chk("rst_mantissa", 32'(out_mantissa), 32'd0);
        chk("rst_zero", 32'(out_zero), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed cases
        run_op(25'h0000100, 1'b0, 0);   // trailing, 8 zeros
        run_op(25'h0010000, 1'b1, 0);   // leading, 8 zeros
        run_op(25'h0000000, 1'b0, 0);   // all zero, trailing
        run_op(25'h0000000, 1'b1, 0);   // all zero, leading
        run_op(25'h1000000, 1'b0, 0);   // 24 trailing zeros, partial last chunk
        run_op(25'h0000001, 1'b1, 0);   // 24 leading zeros
        run_op(25'h1FFFFFF, 1'b0, 0);
        run_op(25'h1FFFFFF, 1'b1, 0);
        run_op(25'h0000100, 1'b0, 5);   // back-pressure

        // Reset in the first BUSY cycle of an all-zero operand
        @(negedge clk);
        in_valid    = 1'b1;
        in_mantissa = '0;
        in_mode     = 1'b0;
        out_ready   = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_count", 32'(out_count), 32'd0);
        chk("abort_mantissa", 32'(out_mantissa), 32'd0);
        chk("abort_zero", 32'(out_zero), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("abort_no_valid", 32'(out_valid), 32'd0);
        end
        rst_n = 1'b1;
        run_op(25'h0000001, 1'b0, 0);

        // Random operands with varied zero runs
        for (int i = 0; i < 10000; i++) begin
            r = W'($urandom);
            k = $urandom_range(0, W);
            if ($urandom_range(0, 1) == 1) r = r >> k;
            else                            r = r << k;
            run_op(r, 1'($urandom), ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
